fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/pc_reg.sv | 36 +++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU front end.
package cpu_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [PC_W-1:0]    RESET_PC   = 16'h0000;
    localparam logic [PC_W-1:0]    IMEM_LAST  = 16'h0062;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } if_id_t;

    // Instructions are halfword aligned; clear the byte-select bit
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(1);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection: redirect, hold, wrap or step by 2.
import cpu_pkg::*;

module pc_reg (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            hold,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] next_pc;

    // Next-PC mux; a redirect overrides any hold request
    always_comb begin
        next_pc = pc + PC_W'(2);
        if (branch_taken) begin
            next_pc = align_pc(branch_target);
        end else if (hold) begin
            next_pc = pc;
        end else if (pc == IMEM_LAST) begin
            next_pc = RESET_PC;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IF/ID register, stall/redirect and HALT handling.
import cpu_pkg::*;

module fetch_unit (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               halted
);

    fetch_state_t state;
    if_id_t       if_id;
    logic         halt_hit;
    logic         pc_hold;

    // HALT only counts when the word would actually be accepted this cycle
    assign halt_hit = (state == FETCH_RUN) && !stall && !branch_taken
                      && (instruction == HALT_INSTR);
    assign pc_hold  = stall || (state == FETCH_HALT) || halt_hit;

    pc_reg u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .hold          (pc_hold),
        .pc            (pc)
    );

    // IF/ID register: squash on redirect, hold on stall, bubble while halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
        end else if (branch_taken) begin
            if_id <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
        end else if (stall) begin
            if_id <= if_id;
        end else if (state == FETCH_HALT) begin
            if_id.instr <= NOP_INSTR;
            if_id.valid <= 1'b0;
        end else begin
            if_id <= '{instr: instruction, pc: pc, valid: 1'b1};
        end
    end

    assign if_id_instr = if_id.instr;
    assign if_id_pc    = if_id.pc;
    assign if_id_valid = if_id.valid;

    // RUN/HALT state machine with registered halted flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH_RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                FETCH_RUN: begin
                    if (halt_hit) begin
                        state  <= FETCH_HALT;
                        halted <= 1'b1;
                    end
                end
                FETCH_HALT: begin
                    if (branch_taken) begin
                        state  <= FETCH_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= FETCH_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem_arr [0:127];

    // reference model state
    logic [15:0] m_pc, m_ifi, m_ifp;
    logic        m_ifv, m_halted;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .instruction   (instruction),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // combinational instruction memory
    always_comb instruction = mem_arr[pc[7:1]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: one fetch step per clock from the rules of the stage
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 16'h0000; m_ifi = 16'h0000; m_ifp = 16'h0000;
            m_ifv = 1'b0; m_halted = 1'b0;
        end else begin
            logic [15:0] word, npc;
            logic        go_halt;
            word    = mem_arr[m_pc[7:1]];
            go_halt = !m_halted && !stall && !branch_taken && (word == 16'hFFFF);
            if (branch_taken)                     npc = {branch_target[15:1], 1'b0};
            else if (m_halted || stall || go_halt) npc = m_pc;
            else if (m_pc == 16'h0062)            npc = 16'h0000;
            else                                  npc = m_pc + 16'd2;
            if (branch_taken) begin
                m_ifi = 16'h0000; m_ifp = 16'h0000; m_ifv = 1'b0;
            end else if (stall) begin
                // IF/ID frozen
            end else if (m_halted) begin
                m_ifi = 16'h0000; m_ifv = 1'b0;
            end else begin
                m_ifi = word; m_ifp = m_pc; m_ifv = 1'b1;
            end
            if (branch_taken)  m_halted = 1'b0;
            else if (go_halt)  m_halted = 1'b1;
            m_pc = npc;
        end
    end

    // compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        check("model_pc",    32'(pc),          32'(m_pc));
        check("model_instr", 32'(if_id_instr), 32'(m_ifi));
        check("model_ifpc",  32'(if_id_pc),    32'(m_ifp));
        check("model_valid", 32'(if_id_valid), 32'(m_ifv));
        check("model_halt",  32'(halted),      32'(m_halted));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [15:0] target, input string name);
        int n = 0;
        while (pc != target && n < 200) begin
            step();
            n++;
        end
        check(name, 32'(pc), 32'(target));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_arr[i] = 16'(2 * i) + 16'h1000;
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        #2;
        check("rst_pc",    32'(pc),          32'h0000);
        check("rst_valid", 32'(if_id_valid), 32'h0);
        check("rst_instr", 32'(if_id_instr), 32'h0000);
        check("rst_halt",  32'(halted),      32'h0);
        #10 rst_n = 1'b1;

        // free-running fetch
        step();
        check("seq_pc2", 32'(pc), 32'h0002);
        step();
        check("seq_pc4",    32'(pc),          32'h0004);
        check("seq_ifpc",   32'(if_id_pc),    32'h0002);
        check("seq_instr",  32'(if_id_instr), 32'h1002);
        check("seq_valid",  32'(if_id_valid), 32'h1);
        step();
        check("seq_pc6", 32'(pc), 32'h0006);

        // three stalled cycles
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_pc",    32'(pc),          32'h0006);
            check("stall_instr", 32'(if_id_instr), 32'h1004);
            check("stall_ifpc",  32'(if_id_pc),    32'h0004);
        end
        stall = 1'b0;
        step();
        check("unstall_instr", 32'(if_id_instr), 32'h1006);
        check("unstall_ifpc",  32'(if_id_pc),    32'h0006);
        check("unstall_pc",    32'(pc),          32'h0008);

        // redirect together with stall, odd target
        branch_taken = 1'b1; branch_target = 16'h0021; stall = 1'b1;
        step();
        check("br_pc",    32'(pc),          32'h0020);
        check("br_valid", 32'(if_id_valid), 32'h0);
        check("br_instr", 32'(if_id_instr), 32'h0000);
        branch_taken = 1'b0; stall = 1'b0;
        step();
        check("br_next_instr", 32'(if_id_instr), 32'h1020);
        check("br_next_ifpc",  32'(if_id_pc),    32'h0020);

        // wrap at the last instruction address
        run_to(16'h0062, "reach_62");
        step();
        check("wrap_pc",    32'(pc),          32'h0000);
        check("wrap_ifpc",  32'(if_id_pc),    32'h0062);
        check("wrap_valid", 32'(if_id_valid), 32'h1);
        step();
        check("wrap2_ifpc",  32'(if_id_pc),    32'h0000);
        check("wrap2_valid", 32'(if_id_valid), 32'h1);

        // HALT word at address 8
        mem_arr[4] = 16'hFFFF;
        run_to(16'h0008, "reach_8");
        step();
        check("halt_instr", 32'(if_id_instr), 32'hFFFF);
        check("halt_ifpc",  32'(if_id_pc),    32'h0008);
        check("halt_valid", 32'(if_id_valid), 32'h1);
        check("halt_flag",  32'(halted),      32'h1);
        check("halt_pc",    32'(pc),          32'h0008);
        for (int k = 0; k < 3; k++) begin
            step();
            check("halted_pc",    32'(pc),          32'h0008);
            check("halted_valid", 32'(if_id_valid), 32'h0);
        end
        branch_taken = 1'b1; branch_target = 16'h0010;
        step();
        check("resume_halt", 32'(halted), 32'h0);
        check("resume_pc",   32'(pc),     32'h0010);
        branch_taken = 1'b0;
        mem_arr[4] = 16'h1008;

        // asynchronous reset between edges
        run_to(16'h0014, "reach_14");
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc",    32'(pc),          32'h0000);
        check("arst_valid", 32'(if_id_valid), 32'h0);
        check("arst_halt",  32'(halted),      32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 128; i++)
            mem_arr[i] = ($urandom_range(0, 11) == 0) ? 16'hFFFF : 16'($urandom());
        for (int c = 0; c < 3000; c++) begin
            step();
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        stall = 1'b0; branch_taken = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
